spdif_frame_sched: RTL

Subframe scheduler for the S/PDIF transmitter. It accepts stereo 24-bit sample pairs from an upstream source through a two-entry buffer. It sequences subframe, frame and 192-frame block position, and presents the core with the next subframe's payload, preamble type, channel-status bit and parity. It also drives the subframe, frame and block status pins in the top level.

---
 rtl/spdif_pkg.sv | 23 ++
 rtl/spdif_pair_fifo.sv | 50 +++++
 rtl/spdif_frame_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF subframe scheduler.
package spdif_pkg;

   localparam int unsigned SAMPLE_W         = 24;
   localparam int unsigned SF_PAYLOAD_W     = 28;
   localparam int unsigned FRAMES_PER_BLOCK = 192;
   localparam int unsigned CS_BITS          = 32;
   localparam int unsigned PAIR_W           = 2 * SAMPLE_W;

   // Preamble type presented to the core
   typedef enum logic [1:0] {
      PRE_B = 2'd0,
      PRE_M = 2'd1,
      PRE_W = 2'd2
   } pre_t;

   // Subframe position within a frame
   typedef enum logic {
      SF_LEFT  = 1'b0,
      SF_RIGHT = 1'b1
   } sf_t;

endpackage

// File: rtl/spdif_pair_fifo.sv
// Two-entry FIFO of {left, right} sample pairs with a registered occupancy count.
module spdif_pair_fifo
   import spdif_pkg::*;
#(
   parameter int unsigned WIDTH = PAIR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

endmodule

// File: rtl/spdif_frame_sched.sv
// Subframe scheduler: tracks subframe/frame/block position and registers the
// payload, preamble and status for the next subframe the core will send.
module spdif_frame_sched
   import spdif_pkg::*;
#(
   parameter logic [31:0] CS_WORD = 32'h0300_0004
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    S_VALID,
   output logic                    S_READY,
   input  logic [SAMPLE_W-1:0]     S_LEFT,
   input  logic [SAMPLE_W-1:0]     S_RIGHT,
   input  logic                    MUTE,
   input  logic                    SF_REQ,
   output logic [SF_PAYLOAD_W-1:0] SF_WORD,
   output logic [1:0]              SF_PRE,
   output logic                    STAT_SF,
   output logic                    STAT_FRM,
   output logic                    STAT_BLK,
   output logic                    UNDERRUN,
   input  logic                    CLR_UNDERRUN
);

   localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);
   localparam logic [7:0] CS_FRAMES  = 8'(CS_BITS);

   // Reset word: invalid, silent left subframe of frame 0
   localparam logic [SF_PAYLOAD_W-1:0] RST_WORD =
      {~CS_WORD[0], CS_WORD[0], 1'b0, 1'b1, {SAMPLE_W{1'b0}}};

   sf_t               sf_q, sf_d;
   logic [7:0]        frame_q, frame_d;
   logic [PAIR_W-1:0] pair_q, pair_d;
   logic              v_q, v_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic [PAIR_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              underrun_set;

   logic [SAMPLE_W-1:0]     audio_d;
   logic                    c_d;
   logic                    p_d;
   pre_t                    pre_d;
   logic [SF_PAYLOAD_W-1:0] word_d;

   assign S_READY   = !fifo_full;
   assign fifo_push = S_VALID && S_READY;

   spdif_pair_fifo #(
      .WIDTH (PAIR_W)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({S_LEFT, S_RIGHT}),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Position state, pair register and validity
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sf_q    <= SF_LEFT;
         frame_q <= '0;
         pair_q  <= '0;
         v_q     <= 1'b1;
      end else begin
         sf_q    <= sf_d;
         frame_q <= frame_d;
         pair_q  <= pair_d;
         v_q     <= v_d;
      end
   end

   // Next position and pair load on each subframe request
   always_comb begin
      sf_d         = sf_q;
      frame_d      = frame_q;
      pair_d       = pair_q;
      v_d          = v_q;
      fifo_pop     = 1'b0;
      underrun_set = 1'b0;
      if (SF_REQ) begin
         case (sf_q)
            SF_LEFT: begin
               sf_d = SF_RIGHT;
            end
            default: begin
               sf_d    = SF_LEFT;
               frame_d = (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  pair_d   = fifo_head;
                  v_d      = 1'b0;
               end else begin
                  pair_d       = '0;
                  v_d          = 1'b1;
                  underrun_set = 1'b1;
               end
            end
         endcase
      end
   end

   // Payload, channel status, parity and preamble of the next subframe
   always_comb begin
      audio_d = (sf_d == SF_RIGHT) ? pair_d[SAMPLE_W-1:0] : pair_d[PAIR_W-1:SAMPLE_W];
      if (MUTE) begin
         audio_d = '0;
      end
      c_d = (frame_d < CS_FRAMES) ? CS_WORD[frame_d[4:0]] : 1'b0;
      p_d = c_d ^ v_d ^ (^audio_d);
      word_d = {p_d, c_d, 1'b0, v_d, audio_d};
      if (sf_d == SF_RIGHT) begin
         pre_d = PRE_W;
      end else if (frame_d == 8'd0) begin
         pre_d = PRE_B;
      end else begin
         pre_d = PRE_M;
      end
   end

   // Presented outputs only move on the edge that samples a request
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         SF_WORD  <= RST_WORD;
         SF_PRE   <= PRE_B;
         STAT_SF  <= 1'b0;
         STAT_FRM <= 1'b0;
         STAT_BLK <= 1'b1;
      end else if (SF_REQ) begin
         SF_WORD  <= word_d;
         SF_PRE   <= pre_d;
         STAT_SF  <= (sf_d == SF_RIGHT);
         STAT_BLK <= (frame_d == 8'd0);
         if (sf_q == SF_RIGHT) begin
            STAT_FRM <= ~STAT_FRM;
         end
      end
   end

   // Sticky underrun flag; a new underrun beats a coincident clear
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         UNDERRUN <= 1'b0;
      end else if (underrun_set) begin
         UNDERRUN <= 1'b1;
      end else if (CLR_UNDERRUN) begin
         UNDERRUN <= 1'b0;
      end
   end

endmodule
